load_seq_ctrl: RTL and testbench

//   Sequences data-memory loads for the core: accepts one load request, issues word reads
//   to synchronous data memory, waits the fixed read latency, extracts and sign/zero-extends
//   the requested byte/half/word, and returns the result through a valid/ready handshake.

---
 rtl/load_seq_ctrl.sv | 115 +++++++++++
 tb/tb_load_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/load_seq_ctrl.sv
// Load sequencer: issues one or two word reads to synchronous data memory, merges them,
// and returns the sign/zero-extended byte/half/word through a valid/ready response.
module load_seq_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_fnc,
  output logic        mem_en,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  // Valid/ready: a request transfers on req_valid & req_ready; a response transfers on
  // rsp_valid & rsp_ready, and rsp_data/rsp_err hold steady while rsp_valid is high.

  typedef enum logic [2:0] {IDLE, ISS0, WAIT0, ISS1, WAIT1, RESP} state_t;

  // Counter is 2 bits wide, enough for the supported read latency of 1..3.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [2:0]  fnc_q;
  logic [1:0]  cnt_q;
  logic [31:0] lo_q;
  logic        legal_fnc;
  logic        split;
  logic [31:0] lo_w, hi_w, m_w, ext_w;

  always_comb begin
    legal_fnc = 1'b0;
    case (req_fnc)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_fnc = 1'b1;
      default: legal_fnc = 1'b0;
    endcase
  end

  // Half loads only cross a word at offset 3; word loads at any nonzero offset.
  assign split = ((fnc_q[1:0] == 2'b01) && (addr_q[1:0] == 2'b11)) ||
                 ((fnc_q == 3'b010) && (addr_q[1:0] != 2'b00));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = legal_fnc ? ISS0 : RESP;
      ISS0:  state_nxt = WAIT0;
      WAIT0: if (cnt_q == 2'd0) state_nxt = split ? ISS1 : RESP;
      ISS1:  state_nxt = WAIT1;
      WAIT1: if (cnt_q == 2'd0) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In WAIT1 the high word is on the bus; otherwise the bus carries the only (low) word.
  always_comb begin
    lo_w = mem_rdata;
    hi_w = 32'd0;
    if (state == WAIT1) begin
      lo_w = lo_q;
      hi_w = mem_rdata;
    end
    m_w = 32'({hi_w, lo_w} >> {addr_q[1:0], 3'b000});
    case (fnc_q)
      3'b000:  ext_w = {{24{m_w[7]}}, m_w[7:0]};
      3'b001:  ext_w = {{16{m_w[15]}}, m_w[15:0]};
      3'b100:  ext_w = {24'd0, m_w[7:0]};
      3'b101:  ext_w = {16'd0, m_w[15:0]};
      default: ext_w = m_w;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= 32'd0;
      fnc_q    <= 3'd0;
      cnt_q    <= 2'd0;
      lo_q     <= 32'd0;
      mem_en   <= 1'b0;
      mem_addr <= 30'd0;
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_en <= (state_nxt == ISS0) || (state_nxt == ISS1);
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        fnc_q  <= req_fnc;
      end
      if (state_nxt == ISS0) mem_addr <= req_addr[31:2];
      else if (state_nxt == ISS1) mem_addr <= addr_q[31:2] + 30'd1;
      if (state == ISS0 || state == ISS1) cnt_q <= CNT_INIT;
      else if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
      if (state == WAIT0 && cnt_q == 2'd0) lo_q <= mem_rdata;
      // Only an illegal request reaches RESP directly from IDLE.
      if (state_nxt == RESP && state != RESP) begin
        rsp_err  <= (state == IDLE);
        rsp_data <= (state == IDLE) ? 32'd0 : ext_w;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Bench for load_seq_ctrl: directed and random loads against a byte-level memory model.
module tb_load_seq_ctrl;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_fnc;
  logic        mem_en;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [logic [29:0]];
  logic [29:0] mem_log [$];
  logic [31:0] pipe [LAT];

  load_seq_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_fnc(req_fnc), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return ({a, 2'b00} * 32'h9E3779B1) ^ 32'h5A3C96E1;
  endfunction

  // Synchronous memory with LAT cycles of read latency; garbage when no read is due.
  always @(posedge clk) begin
    pipe[0] <= mem_en ? mem_rd(mem_addr) : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_en) mem_log.push_back(mem_addr);
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: assemble the load byte by byte from memory, then extend.
  task automatic model(input logic [31:0] addr, input logic [2:0] fnc,
                       output logic [31:0] data, output logic err, output int nwords);
    int size;
    bit sgn;
    logic [31:0] v, a, last;
    data = 32'd0; err = 1'b0; nwords = 0;
    case (fnc)
      3'b000: begin size = 1; sgn = 1; end
      3'b001: begin size = 2; sgn = 1; end
      3'b010: begin size = 4; sgn = 0; end
      3'b100: begin size = 1; sgn = 0; end
      3'b101: begin size = 2; sgn = 0; end
      default: begin err = 1'b1; return; end
    endcase
    v = 32'd0;
    for (int i = 0; i < size; i++) begin
      a = addr + 32'(i);
      v = v | (((mem_rd(a[31:2]) >> (8 * a[1:0])) & 32'hFF) << (8 * i));
    end
    if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
    data = v;
    last = addr + 32'(size - 1);
    nwords = (last[31:2] != addr[31:2]) ? 2 : 1;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] fnc, input int bp);
    logic [31:0] ed, d0;
    logic        ee, e0;
    int          nw, cyc, exp_lat;
    bit          busy_bad, unstable;
    logic [29:0] exp_q [$];
    model(addr, fnc, ed, ee, nw);
    exp_lat = (nw == 0) ? 1 : (nw == 1) ? LAT + 2 : 2 * LAT + 3;
    if (nw >= 1) exp_q.push_back(addr[31:2]);
    if (nw == 2) exp_q.push_back(addr[31:2] + 30'd1);
    @(negedge clk);
    mem_log.delete();
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = addr; req_fnc = fnc; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; busy_bad = 0;
    while (!rsp_valid && cyc < 40) begin
      if (req_ready) busy_bad = 1;
      @(negedge clk);
      cyc++;
    end
    chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("busy_req_ready", {31'd0, busy_bad}, 32'd0);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
    d0 = rsp_data; e0 = rsp_err; unstable = 0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_err !== e0 ||
          req_ready !== 1'b0 || mem_en !== 1'b0) unstable = 1;
    end
    if (bp > 0) chk("backpressure_hold", {31'd0, unstable}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
    chk("mem_reads", 32'(mem_log.size()), 32'(nw));
    if (mem_log.size() == exp_q.size())
      foreach (exp_q[i]) chk("mem_addr", {2'b00, mem_log[i]}, {2'b00, exp_q[i]});
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf;
    logic [2:0]  fnc_tab [8];
    fnc_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_fnc = 3'd0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    mem[30'h40] = 32'hDEADBEEF;
    do_load(32'h100, 3'b010, 0);
    mem[30'h40] = 32'h80FF7F01;
    do_load(32'h103, 3'b000, 0);
    do_load(32'h103, 3'b100, 0);
    do_load(32'h102, 3'b001, 5);
    mem[30'h3F] = 32'h44332211;
    mem[30'h40] = 32'h88776655;
    do_load(32'h0FE, 3'b010, 0);
    do_load(32'h0FF, 3'b101, 0);
    do_load(32'h0FF, 3'b001, 3);
    do_load(32'h104, 3'b011, 2);
    do_load(32'hFFFFFFFD, 3'b010, 0);
    do_load(32'hFFFFFFFF, 3'b001, 0);

    // Reset while the first read's data is on the bus.
    mem[30'h50] = 32'h11112222;
    mem[30'h80] = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h140; req_fnc = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("midrst_mem_addr", {2'b00, mem_addr}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_load(32'h200, 3'b010, 0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      rf = fnc_tab[$urandom_range(0, 7)];
      do_load(ra, rf, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
